mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 171 +++++++++++++++++
 tb/tb_mult_div_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: 32-bit iterative multiply/divide unit with HI/LO result
// registers. Multiply is radix-2 shift-add and divide is restoring
// shift-subtract. Every mult/div takes 32 ITER cycles plus one FIX cycle.
module mult_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        md_start,
  input  logic [2:0]  md_control,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

  state_t      state_reg, state_next;
  logic [5:0]  cnt_reg;
  logic        is_div_reg;
  logic        neg_q_reg;     // product sign (mult) or quotient sign (div)
  logic        neg_r_reg;     // remainder follows the dividend sign
  logic        div_zero_reg;
  logic [31:0] opb_reg;       // multiplicand or divisor magnitude
  logic [31:0] acc_hi_reg;    // partial product high half / partial remainder
  logic [31:0] acc_lo_reg;    // multiplier bits / dividend bits turning into quotient
  logic [31:0] res_hi_reg, res_lo_reg;
  logic        done_reg;

  logic        accept;
  logic        start_md;
  logic        md_signed;
  logic [31:0] op_in  [2];
  logic [31:0] op_mag [2];

  assign accept    = (state_reg == IDLE) && md_start;
  assign start_md  = accept && !md_control[2];
  assign md_signed = !md_control[0];

  assign op_in[0] = rs_data;
  assign op_in[1] = rt_data;

  // Signed ops run on operand magnitudes; unsigned ops pass operands through.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_mag
      assign op_mag[gi] = (md_signed && op_in[gi][31]) ? (~op_in[gi] + 32'd1) : op_in[gi];
    end
  endgenerate

  // One iteration step of each algorithm, evaluated from the accumulators.
  logic [32:0] mul_sum;
  logic [31:0] mul_hi_step, mul_lo_step;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_diff;
  logic [31:0] div_hi_step, div_lo_step;

  // Shift-add and restoring shift-subtract datapath for one bit.
  always_comb begin
    mul_sum     = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, opb_reg} : 33'd0);
    mul_hi_step = mul_sum[32:1];
    mul_lo_step = {mul_sum[0], acc_lo_reg[31:1]};
    div_shift   = {acc_hi_reg, acc_lo_reg[31]};
    div_ge      = (div_shift >= {1'b0, opb_reg});
    // Only used when div_ge holds, so the true difference fits in 32 bits.
    div_diff    = div_shift[31:0] - opb_reg;
    div_hi_step = div_ge ? div_diff : div_shift[31:0];
    div_lo_step = {acc_lo_reg[30:0], div_ge};
  end

  // Sign correction and divide-by-zero override applied in FIX.
  logic [63:0] prod, prod_neg;
  logic [31:0] fix_hi, fix_lo;

  // Final HI/LO values computed from the magnitude results.
  always_comb begin
    prod     = {acc_hi_reg, acc_lo_reg};
    prod_neg = ~prod + 64'd1;
    fix_hi   = 32'd0;
    fix_lo   = 32'd0;
    if (is_div_reg) begin
      fix_hi = neg_r_reg ? (~acc_hi_reg + 32'd1) : acc_hi_reg;
      if (div_zero_reg)
        fix_lo = 32'hFFFF_FFFF;
      else
        fix_lo = neg_q_reg ? (~acc_lo_reg + 32'd1) : acc_lo_reg;
    end else begin
      fix_hi = neg_q_reg ? prod_neg[63:32] : prod[63:32];
      fix_lo = neg_q_reg ? prod_neg[31:0]  : prod[31:0];
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  // FSM next-state logic: only IDLE accepts a mult/div request.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_md) state_next = ITER;
      ITER:    if (cnt_reg == 6'd31) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand latch, iteration accumulators and HI/LO/done updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg      <= 6'd0;
      is_div_reg   <= 1'b0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      div_zero_reg <= 1'b0;
      opb_reg      <= 32'd0;
      acc_hi_reg   <= 32'd0;
      acc_lo_reg   <= 32'd0;
      res_hi_reg   <= 32'd0;
      res_lo_reg   <= 32'd0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_md) begin
            cnt_reg      <= 6'd0;
            is_div_reg   <= md_control[1];
            neg_q_reg    <= md_signed && (rs_data[31] ^ rt_data[31]);
            neg_r_reg    <= md_signed && rs_data[31];
            div_zero_reg <= (rt_data == 32'd0);
            opb_reg      <= op_mag[1];
            acc_hi_reg   <= 32'd0;
            acc_lo_reg   <= op_mag[0];
          end else if (accept && md_control == 3'b100) begin
            res_hi_reg <= rs_data;
          end else if (accept && md_control == 3'b101) begin
            res_lo_reg <= rs_data;
          end
        end
        ITER: begin
          cnt_reg <= cnt_reg + 6'd1;
          if (is_div_reg) begin
            acc_hi_reg <= div_hi_step;
            acc_lo_reg <= div_lo_step;
          end else begin
            acc_hi_reg <= mul_hi_step;
            acc_lo_reg <= mul_lo_step;
          end
        end
        FIX: begin
          res_hi_reg <= fix_hi;
          res_lo_reg <= fix_lo;
          done_reg   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state_reg != IDLE);
  assign done   = done_reg;
  assign res_hi = res_hi_reg;
  assign res_lo = res_lo_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed plus randomized checks of mult_div_unit. Expected
// {HI,LO} results and their due cycle go into a scoreboard queue at the
// accepting edge; a negedge monitor checks done against the scoreboard every
// cycle and compares HI/LO when the result falls due.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        md_start;
  logic [2:0]  md_control;
  logic [31:0] rs_data, rt_data;
  logic        busy, done;
  logic [31:0] res_hi, res_lo;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [63:0] res;
    int          due;
    string       tag;
  } exp_t;
  exp_t sb[$];

  mult_div_unit dut (
    .clk        (clk),
    .rst        (rst),
    .md_start   (md_start),
    .md_control (md_control),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .busy       (busy),
    .done       (done),
    .res_hi     (res_hi),
    .res_lo     (res_lo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Independent reference: 64-bit arithmetic on the raw operands.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa64, sb64, p;
    int     sa, sbv;
    logic [31:0] q, r;
    sa64 = longint'($signed(a));
    sb64 = longint'($signed(b));
    sa   = $signed(a);
    sbv  = $signed(b);
    case (op)
      2'd0: begin p = sa64 * sb64; return p; end
      2'd1: return {32'd0, a} * {32'd0, b};
      2'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = sa / sbv;
        r = sa % sbv;
        return {r, q};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Scoreboard monitor: done must pulse exactly when the front entry is due.
  always @(negedge clk) begin
    logic exp_done;
    exp_t e;
    exp_done = (sb.size() > 0) && (sb[0].due == cyc);
    check("done_pulse", {63'd0, done}, {63'd0, exp_done});
    if (exp_done) begin
      e = sb.pop_front();
      check({e.tag, "_hilo"}, {res_hi, res_lo}, e.res);
      $display("txn %s: hi=%h lo=%h at cycle %0d", e.tag, res_hi, res_lo, cyc);
    end
  end

  // Caller is at a negedge with the unit idle; the next posedge accepts.
  task automatic issue(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp);
    exp_t e;
    md_start   = 1'b1;
    md_control = op;
    rs_data    = a;
    rt_data    = b;
    @(posedge clk);
    #1;
    md_start = 1'b0;
    rs_data  = $urandom;
    rt_data  = $urandom;
    e.res = exp;
    e.due = cyc + 33;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Returns at the negedge where done is high, bounded by a cycle budget.
  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check({tag, "_timeout"}, {63'd0, done}, 64'd1);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;

    // Reset with a request held: reset wins.
    rst        = 1'b1;
    md_start   = 1'b1;
    md_control = 3'b000;
    rs_data    = 32'd6;
    rt_data    = 32'd7;
    repeat (3) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_hilo", {res_hi, res_lo}, 64'd0);

    // First edge after reset release accepts.
    rst = 1'b0;
    issue("mult_6x7", 3'b000, 32'd6, 32'd7, 64'd42);
    @(negedge clk);
    check("busy_after_accept", {63'd0, busy}, 64'd1);
    wait_done("mult_6x7");
    check("busy_at_done", {63'd0, busy}, 64'd0);

    @(negedge clk);
    issue("mult_neg3x7", 3'b000, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB);
    wait_done("mult_neg3x7");
    // Accept in the done cycle, back to back.
    issue("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    wait_done("multu_max");
    issue("mult_m1xm1", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
    wait_done("mult_m1xm1");
    issue("div_m7_2", 3'b010, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    wait_done("div_m7_2");
    issue("divu_100_7", 3'b011, 32'd100, 32'd7, {32'd2, 32'd14});
    wait_done("divu_100_7");
    issue("divu_by0", 3'b011, 32'h1234_5678, 32'd0, {32'h1234_5678, 32'hFFFF_FFFF});
    wait_done("divu_by0");
    issue("div_by0", 3'b010, 32'hFFFF_FFF0, 32'd0, {32'hFFFF_FFF0, 32'hFFFF_FFFF});
    wait_done("div_by0");
    issue("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000});
    wait_done("div_ovf");

    // mthi / mtlo write at the accepting edge without going busy.
    @(negedge clk);
    md_start = 1'b1; md_control = 3'b100; rs_data = 32'hA5A5_A5A5;
    @(negedge clk);
    md_start = 1'b0;
    check("mthi_hi", {32'd0, res_hi}, {32'd0, 32'hA5A5_A5A5});
    check("mthi_busy", {63'd0, busy}, 64'd0);
    md_start = 1'b1; md_control = 3'b101; rs_data = 32'h5A5A_5A5A;
    @(negedge clk);
    md_start = 1'b1; md_control = 3'b110; rs_data = 32'hDEAD_BEEF;
    @(negedge clk);
    md_start = 1'b0;
    check("mtlo_mfhi_hilo", {res_hi, res_lo}, {32'hA5A5_A5A5, 32'h5A5A_5A5A});
    check("mtlo_busy", {63'd0, busy}, 64'd0);
    $display("txn mthi/mtlo/mfhi: hi=%h lo=%h", res_hi, res_lo);

    // mult 3*5 with mthi and a new mult issued mid-ITER: both ignored.
    issue("mult_3x5", 3'b000, 32'd3, 32'd5, 64'd15);
    repeat (4) @(negedge clk);
    md_start = 1'b1; md_control = 3'b100; rs_data = 32'h0000_0001;
    @(negedge clk);
    md_start = 1'b1; md_control = 3'b000; rs_data = 32'd9; rt_data = 32'd9;
    @(negedge clk);
    md_start = 1'b0;
    check("iter_hold_hilo", {res_hi, res_lo}, {32'hA5A5_A5A5, 32'h5A5A_5A5A});
    check("iter_busy", {63'd0, busy}, 64'd1);
    wait_done("mult_3x5");
    repeat (40) @(negedge clk);

    // Reset at ITER cycle 10 aborts the divide with no done.
    issue("div_abort_start", 3'b010, 32'd1000, 32'd3, 64'd0);
    void'(sb.pop_back());
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_hilo", {res_hi, res_lo}, 64'd0);
    $display("txn div abort: busy=%b hi=%h lo=%h", busy, res_hi, res_lo);
    repeat (30) @(negedge clk);
    issue("mult_2x2", 3'b000, 32'd2, 32'd2, 64'd4);
    wait_done("mult_2x2");

    // Randomized back-to-back ops against the reference model.
    for (int i = 0; i < 8; i++) begin
      op = 3'($urandom_range(0, 3));
      a  = $urandom;
      b  = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      if (i % 2 == 1) a = -a;
      issue($sformatf("rand%0d_op%0d", i, op), op, a, b, model(op[1:0], a, b));
      wait_done("rand");
    end

    repeat (5) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
